ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
// Pipelined MIPS control unit: decodes the D-stage instruction and carries the control bundle through the E, M and W pipeline registers.
// Detects load-use and branch/jr operand hazards and generates the D-stage stall.
// Produces the E-stage forwarding selects.
// Sits beside the datapath pipeline registers; the datapath consumes the per-stage control outputs directly.
// PARAMETERS
// ALUOP_W    4  ALU op width; encodings 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT, 5 LUI (imm<<16); upper bits zero
// BR_HAZARD  1  1 = stall branch/jr/jalr in D on an unresolved operand; 0 = no branch hazard stall (datapath resolves in E)
// PORTS
// clk         in   1        rising-edge clock
// reset       in   1        asynchronous, active-low reset
// instr_D     in   32       D-stage instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]
// flush_E     in   1        force a bubble into E at next edge
// stall_D     out  1        freeze PC and IF/ID register this cycle
// ext_op_D    out  2        0 zero-ext, 1 sign-ext, 2 upper
// beq_D/bne_D out  1 each   branch type; gated to 0 while stall_D
// j_D         out  1        j/jal/jr/jalr taken; gated to 0 while stall_D
// jr_D        out  1        target from rs (jr/jalr); gated to 0 while stall_D
// illegal_D   out  1        opcode/funct not in the supported set
// alu_src_E   out  1        1 = immediate operand B
// alu_op_E    out  ALUOP_W  ALU operation
// fwd_rs_E    out  2        0 reg file, 1 from W, 2 from M
// fwd_rt_E    out  2        same encoding, rt operand
// waddr_E     out  5        destination register in E
// mem_write_M out  1        store enable
// waddr_M     out  5        destination register in M
// reg_write_W out  1        reg file write enable
// mem_to_reg_W out 1        write-back source is load data
// link_W      out  1        write-back source is PC+8
// waddr_W     out  5        destination register in W
// BEHAVIOUR
// Supported set:
//   R-type: addu subu and or slt jr jalr
//   I-type: ori andi addiu lui lw sw beq bne
//   J-type: j jal
// Illegal instructions:
//   - decode as a NOP bundle (all controls 0); illegal_D = 1.
// Destination register:
//   - rd for R-type ALU ops and jalr.
//   - rt for lw, ori, andi, addiu and lui.
//   - 31 for jal.
//   - Otherwise 0. reg_write is forced to 0 whenever the destination is 0.
// Extension and ALU controls:
//   - Sign-extend: addiu, lw, sw, beq, bne. Zero-extend: ori, andi. Upper: lui.
//   - alu_src = 1 for addiu, ori, andi, lui, lw, sw.
//   - beq/bne use SUB.
//   - link = 1 for jal and jalr.
// Operand use:
//   - uses_rs: all except j, jal, lui.
//   - uses_rt: R-type ALU ops, sw, beq, bne.
// Load-use hazard:
//   - Condition: E holds lw, waddr_E != 0, and waddr_E matches a used rs_D/rt_D.
//   - Result: stall_D = 1.
// Branch hazard (BR_HAZARD=1): for beq/bne/jr/jalr in D, stall_D = 1 when either:
//   - E writes a used operand (reg_write, waddr != 0); or
//   - M holds lw writing a used operand.
// Stall and bubble rules:
//   - Stall is purely combinational from D and E/M state.
//   - On stall_D or flush_E, E loads a bubble: all controls 0, waddr 0, rs/rt 0.
//   - If both are asserted, the result is a bubble (same as either alone).
// Register advance:
//   - Otherwise E loads the decoded D bundle, including rs_D/rt_D.
//   - M <= E and W <= M every cycle, unconditionally.
// Forwarding (per operand; rs_E/rt_E = 0 gives 0):
//   - 2 if M has reg_write, is not a load, and waddr_M matches.
//   - Else 1 if W has reg_write and waddr_W matches.
//   - Else 0. M has priority over W.
// Latency:
//   - D outputs are combinational.
//   - E, M and W outputs each lag D by 1, 2 and 3 edges.
// Reset (reset=0, async):
//   - All E/M/W registers clear to the bubble.
//   - All E/M/W outputs and fwd selects read 0.
//   - stall_D is then a function of instr_D only and evaluates to 0.
//   - A reset asserted mid-stall drops the stall and empties the pipe.
// TESTING
// T1 reset: hold reset=0 with instr_D=lw $1; release -> all E/M/W outputs 0 until the first edge; no spurious stall.
// T2 decode/latency: addu $3,$1,$2 at D cycle 0 -> alu_op_E=0, waddr_E=3 at cycle 1; reg_write_W=1, waddr_W=3 at cycle 3.
// T3 load-use: lw $5,0($1) then addu $6,$5,$2:
//   - stall_D=1 for exactly 1 cycle; bubble enters E.
//   - addu reaches E with fwd_rs_E=1 while the lw is in W.
// T4 forwarding priority:
//   - addu $4,... ; ori $4,... ; subu $7,$4,$4 -> fwd_rs_E=fwd_rt_E=2 (M wins).
//   - Writes to $0 never forward.
// T5 branch hazard: addiu $8,... then beq $8,$9:
//   - stall_D=1 one cycle with beq_D gated to 0, then beq_D=1.
//   - With BR_HAZARD=0: no stall.
// T6 flush and illegal:
//   - flush_E=1 together with stall -> bubble in E.
//   - op=6'b111111 -> illegal_D=1 and NOP bundle down the pipe.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control unit: D-stage decode, E/M/W control registers,
// load-use and branch-operand stall generation, and E-stage forwarding selects.
module ctrl_pipe #(
  parameter int ALUOP_W   = 4,
  parameter bit BR_HAZARD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr_D,
  input  logic               flush_E,
  output logic               stall_D,
  output logic [1:0]         ext_op_D,
  output logic               beq_D,
  output logic               bne_D,
  output logic               j_D,
  output logic               jr_D,
  output logic               illegal_D,
  output logic               alu_src_E,
  output logic [ALUOP_W-1:0] alu_op_E,
  output logic [1:0]         fwd_rs_E,
  output logic [1:0]         fwd_rt_E,
  output logic [4:0]         waddr_E,
  output logic               mem_write_M,
  output logic [4:0]         waddr_M,
  output logic               reg_write_W,
  output logic               mem_to_reg_W,
  output logic               link_W,
  output logic [4:0]         waddr_W
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(5);

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic               link;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [4:0]         waddr;
    logic [4:0]         rs;
    logic [4:0]         rt;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       link;
    logic [4:0] waddr;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic [4:0] waddr;
  } ctrl_w_t;

  logic [5:0] op_D, funct_D;
  logic [4:0] rs_D, rt_D, rd_D;

  assign op_D    = instr_D[31:26];
  assign rs_D    = instr_D[25:21];
  assign rt_D    = instr_D[20:16];
  assign rd_D    = instr_D[15:11];
  assign funct_D = instr_D[5:0];

  // shamt is never consumed by this instruction subset
  logic unused_shamt;
  assign unused_shamt = ^instr_D[10:6];

  ctrl_e_t dec_D;
  logic       r_alu_D, wr_D, illegal_raw_D;
  logic       is_beq_D, is_bne_D, is_j_D, is_jr_D;
  logic       uses_rs_D, uses_rt_D;
  logic [4:0] dest_D;
  logic [1:0] ext_raw_D;

  always_comb begin
    dec_D         = '0;
    r_alu_D       = 1'b0;
    wr_D          = 1'b0;
    illegal_raw_D = 1'b0;
    is_beq_D      = 1'b0;
    is_bne_D      = 1'b0;
    is_j_D        = 1'b0;
    is_jr_D       = 1'b0;
    uses_rs_D     = 1'b0;
    uses_rt_D     = 1'b0;
    dest_D        = 5'd0;
    ext_raw_D     = EXT_ZERO;
    case (op_D)
      OP_RTYPE: begin
        case (funct_D)
          FN_ADDU: begin r_alu_D = 1'b1; dec_D.alu_op = ALU_ADD; end
          FN_SUBU: begin r_alu_D = 1'b1; dec_D.alu_op = ALU_SUB; end
          FN_AND:  begin r_alu_D = 1'b1; dec_D.alu_op = ALU_AND; end
          FN_OR:   begin r_alu_D = 1'b1; dec_D.alu_op = ALU_OR;  end
          FN_SLT:  begin r_alu_D = 1'b1; dec_D.alu_op = ALU_SLT; end
          FN_JR: begin
            is_j_D    = 1'b1;
            is_jr_D   = 1'b1;
            uses_rs_D = 1'b1;
          end
          FN_JALR: begin
            is_j_D     = 1'b1;
            is_jr_D    = 1'b1;
            uses_rs_D  = 1'b1;
            wr_D       = 1'b1;
            dest_D     = rd_D;
            dec_D.link = 1'b1;
          end
          default: illegal_raw_D = 1'b1;
        endcase
        if (r_alu_D) begin
          wr_D      = 1'b1;
          dest_D    = rd_D;
          uses_rs_D = 1'b1;
          uses_rt_D = 1'b1;
        end
      end
      OP_ADDIU, OP_ORI, OP_ANDI, OP_LW: begin
        wr_D          = 1'b1;
        dest_D        = rt_D;
        uses_rs_D     = 1'b1;
        dec_D.alu_src = 1'b1;
        case (op_D)
          OP_ORI:  begin dec_D.alu_op = ALU_OR;  ext_raw_D = EXT_ZERO; end
          OP_ANDI: begin dec_D.alu_op = ALU_AND; ext_raw_D = EXT_ZERO; end
          default: begin dec_D.alu_op = ALU_ADD; ext_raw_D = EXT_SIGN; end
        endcase
        dec_D.mem_to_reg = (op_D == OP_LW);
      end
      OP_LUI: begin
        wr_D          = 1'b1;
        dest_D        = rt_D;
        dec_D.alu_src = 1'b1;
        dec_D.alu_op  = ALU_LUI;
        ext_raw_D     = EXT_UPPER;
      end
      OP_SW: begin
        uses_rs_D       = 1'b1;
        uses_rt_D       = 1'b1;
        dec_D.alu_src   = 1'b1;
        dec_D.alu_op    = ALU_ADD;
        dec_D.mem_write = 1'b1;
        ext_raw_D       = EXT_SIGN;
      end
      OP_BEQ, OP_BNE: begin
        is_beq_D     = (op_D == OP_BEQ);
        is_bne_D     = (op_D == OP_BNE);
        uses_rs_D    = 1'b1;
        uses_rt_D    = 1'b1;
        dec_D.alu_op = ALU_SUB;
        ext_raw_D    = EXT_SIGN;
      end
      OP_J: is_j_D = 1'b1;
      OP_JAL: begin
        is_j_D     = 1'b1;
        wr_D       = 1'b1;
        dest_D     = 5'd31;
        dec_D.link = 1'b1;
      end
      default: illegal_raw_D = 1'b1;
    endcase
    dec_D.waddr     = dest_D;
    dec_D.reg_write = wr_D && (dest_D != 5'd0);
    // illegal opcodes carry no operand fields, so they never forward or stall
    dec_D.rs        = illegal_raw_D ? 5'd0 : rs_D;
    dec_D.rt        = illegal_raw_D ? 5'd0 : rt_D;
  end

  ctrl_e_t e_q, e_d;
  ctrl_m_t m_q, m_d;
  ctrl_w_t w_q, w_d;

  logic hit_e_D, hit_m_D, load_use_D, br_hazard_D, is_branch_D;

  always_comb begin
    hit_e_D = (uses_rs_D && (rs_D == e_q.waddr)) ||
              (uses_rt_D && (rt_D == e_q.waddr));
    hit_m_D = (uses_rs_D && (rs_D == m_q.waddr)) ||
              (uses_rt_D && (rt_D == m_q.waddr));
    load_use_D  = e_q.mem_to_reg && (e_q.waddr != 5'd0) && hit_e_D;
    is_branch_D = is_beq_D || is_bne_D || is_jr_D;
    br_hazard_D = BR_HAZARD && is_branch_D &&
                  ((e_q.reg_write && (e_q.waddr != 5'd0) && hit_e_D) ||
                   (m_q.mem_to_reg && (m_q.waddr != 5'd0) && hit_m_D));
    stall_D     = load_use_D || br_hazard_D;
  end

  assign ext_op_D  = ext_raw_D;
  assign illegal_D = illegal_raw_D;
  assign beq_D     = is_beq_D && !stall_D;
  assign bne_D     = is_bne_D && !stall_D;
  assign j_D       = is_j_D   && !stall_D;
  assign jr_D      = is_jr_D  && !stall_D;

  always_comb begin
    e_d = (stall_D || flush_E) ? '0 : dec_D;
    m_d.reg_write  = e_q.reg_write;
    m_d.mem_to_reg = e_q.mem_to_reg;
    m_d.mem_write  = e_q.mem_write;
    m_d.link       = e_q.link;
    m_d.waddr      = e_q.waddr;
    w_d.reg_write  = m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
    w_d.link       = m_q.link;
    w_d.waddr      = m_q.waddr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // M wins over W; loads in M have no data yet and are left to the stall logic
  always_comb begin
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    if (e_q.rs != 5'd0) begin
      if (m_q.reg_write && !m_q.mem_to_reg && (m_q.waddr == e_q.rs))
        fwd_rs_E = 2'd2;
      else if (w_q.reg_write && (w_q.waddr == e_q.rs))
        fwd_rs_E = 2'd1;
    end
    if (e_q.rt != 5'd0) begin
      if (m_q.reg_write && !m_q.mem_to_reg && (m_q.waddr == e_q.rt))
        fwd_rt_E = 2'd2;
      else if (w_q.reg_write && (w_q.waddr == e_q.rt))
        fwd_rt_E = 2'd1;
    end
  end

  assign alu_src_E    = e_q.alu_src;
  assign alu_op_E     = e_q.alu_op;
  assign waddr_E      = e_q.waddr;
  assign mem_write_M  = m_q.mem_write;
  assign waddr_M      = m_q.waddr;
  assign reg_write_W  = w_q.reg_write;
  assign mem_to_reg_W = w_q.mem_to_reg;
  assign link_W       = w_q.link;
  assign waddr_W      = w_q.waddr;

endmodule
